// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control inputs, instruction-memory port and the IF/ID register outputs.
// The master side is the fetch stage itself; the slave side is its environment (decode, imem, later stages).
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        misalign_err;

  modport master (
    input  stall, flush, redirect, redirect_pc, idata,
    output iaddr, id_inst, id_pc, id_pc4, id_valid, misalign_err
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, idata,
    input  iaddr, id_inst, id_pc, id_pc4, id_valid, misalign_err
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register with redirect/flush/stall control.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirect targets instead of silently aligning them.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  logic [31:0] pc_q, pc_d, pc_plus4, target_pc;
  logic [31:0] pc_base;
  ifid_t       ifid_q, ifid_d, ifid_base, fetched;

  assign pc_plus4  = pc_q + 32'd4;
  assign target_pc = {bus.redirect_pc[31:2], 2'b00};
  assign fetched   = '{inst: bus.idata, pc: pc_q, pc4: pc_plus4, valid: 1'b1};

  // Priority among pipeline events: redirect > flush > stall > advance.
  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_base   = pc_plus4;
    ifid_base = fetched;
    if (bus.redirect) begin
      pc_base   = target_pc;
      ifid_base = BUBBLE;
    end else if (bus.flush) begin
      ifid_base = BUBBLE;
      if (bus.stall) pc_base = pc_q;
    end else if (bus.stall) begin
      pc_base   = pc_q;
      ifid_base = ifid_q;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic {ST_RUN, ST_LOCKED} state_t;

  state_t state_q, state_d;
  logic   target_misaligned;

  assign target_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Once a bad target is seen the stage freezes its PC and emits bubbles until reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_base;
    ifid_d  = ifid_base;
    case (state_q)
      ST_LOCKED: begin
        pc_d   = pc_q;
        ifid_d = BUBBLE;
      end
      default: begin
        if (bus.redirect && target_misaligned) begin
          state_d = ST_LOCKED;
          pc_d    = pc_q;
          ifid_d  = BUBBLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign bus.misalign_err = (state_q == ST_LOCKED);
`else
  logic align_unused;

  assign align_unused     = ^bus.redirect_pc[1:0];
  assign pc_d             = pc_base;
  assign ifid_d           = ifid_base;
  assign bus.misalign_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= BUBBLE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.iaddr    = pc_q;
  assign bus.id_inst  = ifid_q.inst;
  assign bus.id_pc    = ifid_q.pc;
  assign bus.id_pc4   = ifid_q.pc4;
  assign bus.id_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control traffic,
// compared every cycle against a transaction-level model of the fetch stage.
module tb_if_stage;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Expected architectural state of the fetch stage.
  logic [31:0] m_pc;
  logic [31:0] m_inst, m_id_pc, m_id_pc4;
  logic        m_valid, m_err;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.idata = mem_word(bus.iaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic make_bubble();
    m_inst = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit r, input bit st, input bit fl, input bit rd,
                            input logic [31:0] rpc);
    if (r) begin
      m_pc = RST_PC; m_err = 1'b0; make_bubble();
    end else if (m_err) begin
      make_bubble();
    end else if (rd) begin
      if (ALIGN_CHECK && rpc[1:0] != 2'b00) m_err = 1'b1;
      else m_pc = rpc & 32'hFFFF_FFFC;
      make_bubble();
    end else if (fl) begin
      make_bubble();
      if (!st) m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_inst = mem_word(m_pc); m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit fl, input bit rd,
                       input logic [31:0] rpc);
    rst = r; bus.stall = st; bus.flush = fl; bus.redirect = rd; bus.redirect_pc = rpc;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge(rst, bus.stall, bus.flush, bus.redirect, bus.redirect_pc);
    #1;
    check({tag, "_iaddr"},    bus.iaddr,               m_pc);
    check({tag, "_id_inst"},  bus.id_inst,             m_inst);
    check({tag, "_id_pc"},    bus.id_pc,               m_id_pc);
    check({tag, "_id_pc4"},   bus.id_pc4,              m_id_pc4);
    check({tag, "_id_valid"}, {31'b0, bus.id_valid},   {31'b0, m_valid});
    check({tag, "_err"},      {31'b0, bus.misalign_err}, {31'b0, m_err});
  endtask

  initial begin
    logic [31:0] held_inst;
    m_pc = 32'h0; m_err = 1'b0; make_bubble();

    // Reset held two cycles, then the first two fetches.
    drive(1, 0, 0, 0, 32'h0);
    cycle("rst0");
    cycle("rst1");
    check("rst_iaddr", bus.iaddr, RST_PC);
    drive(0, 0, 0, 0, 32'h0);
    cycle("fetch0");
    check("fetch0_inst", bus.id_inst, 32'h2008_0005);
    check("fetch0_pc4", bus.id_pc4, 32'h4);
    cycle("fetch1");
    check("fetch1_inst", bus.id_inst, 32'h2009_0003);
    check("fetch1_pc", bus.id_pc, 32'h4);

    // Stall three cycles at pc=8.
    held_inst = bus.id_inst;
    drive(0, 1, 0, 0, 32'h0);
    repeat (3) cycle("stall");
    check("stall_iaddr", bus.iaddr, 32'h8);
    check("stall_hold", bus.id_inst, held_inst);
    drive(0, 0, 0, 0, 32'h0);
    cycle("unstall");
    check("unstall_pc", bus.id_pc, 32'h8);
    cycle("adv");

    // Redirect from pc=0x10 to 0x40.
    check("pre_redir_iaddr", bus.iaddr, 32'h10);
    drive(0, 0, 0, 1, 32'h40);
    cycle("redir");
    check("redir_iaddr", bus.iaddr, 32'h40);
    check("redir_valid", {31'b0, bus.id_valid}, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    cycle("redir_next");
    check("redir_next_pc", bus.id_pc, 32'h40);

    // Redirect overrides stall.
    drive(0, 1, 0, 1, 32'h80);
    cycle("redir_stall");
    check("redir_stall_iaddr", bus.iaddr, 32'h80);

    // Flush with and without stall at pc=0x20.
    drive(0, 0, 0, 1, 32'h20);
    cycle("to20");
    drive(0, 1, 1, 0, 32'h0);
    cycle("flush_stall");
    check("flush_stall_iaddr", bus.iaddr, 32'h20);
    drive(0, 0, 1, 0, 32'h0);
    cycle("flush");
    check("flush_iaddr", bus.iaddr, 32'h24);

    // Randomized control traffic, occasionally resetting.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rpc;
      rpc = $urandom();
      if (ALIGN_CHECK) rpc[1:0] = 2'b00;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10, rpc);
      cycle("rand");
    end

    // PC wrap from the top of the address space.
    drive(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle("to_top");
    drive(0, 0, 0, 0, 32'h0);
    cycle("wrap");
    check("wrap_iaddr", bus.iaddr, 32'h0);
    check("wrap_pc4", bus.id_pc4, 32'h0);

    // Reset in the middle of a redirect plus stall.
    drive(1, 1, 0, 1, 32'h100);
    cycle("mid_rst");
    check("mid_rst_iaddr", bus.iaddr, RST_PC);
    drive(0, 0, 0, 0, 32'h0);
    cycle("post_rst");
    check("post_rst_pc", bus.id_pc, RST_PC);

    // Misaligned redirect target from pc=4.
    drive(0, 0, 0, 1, 32'h42);
    cycle("misal");
    if (ALIGN_CHECK) begin
      check("misal_iaddr", bus.iaddr, 32'h4);
      check("misal_err", {31'b0, bus.misalign_err}, 32'h1);
      drive(0, 0, 0, 1, 32'h100);
      cycle("locked_redir");
      check("locked_iaddr", bus.iaddr, 32'h4);
      drive(0, 0, 0, 0, 32'h0);
      cycle("locked_idle");
      check("locked_valid", {31'b0, bus.id_valid}, 32'h0);
      drive(1, 0, 0, 0, 32'h0);
      cycle("unlock_rst");
      check("unlock_err", {31'b0, bus.misalign_err}, 32'h0);
    end else begin
      check("misal_iaddr", bus.iaddr, 32'h40);
      check("misal_err", {31'b0, bus.misalign_err}, 32'h0);
    end
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) cycle("tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hazard hold request from decode.
REQ-005 SHALL have port flush  input  1  kill request: squash the IF/ID contents.
REQ-006 SHALL have port redirect  input  1  taken branch or jump from a later stage.
REQ-007 SHALL have port redirect_pc  input  32  branch or jump target address.
REQ-008 SHALL have port iaddr  output  32  instruction-memory byte address.
REQ-009 SHALL have port idata  input  32  instruction word returned combinationally by instruction memory.
REQ-010 SHALL have port id_inst  output  32  IF/ID instruction.
REQ-011 SHALL have port id_pc  output  32  IF/ID instruction address.
REQ-012 SHALL have port id_pc4  output  32  IF/ID id_pc+4.
REQ-013 SHALL have port id_valid  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-015 SHALL drive iaddr combinationally from the internal pc register, with no added latency.
REQ-016 SHALL present an instruction fetched at pc on id_* exactly one cycle later, as {idata, pc, pc+4, valid=1}.
REQ-017 SHALL, on each edge with no event, update pc to pc+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000, and id_pc4 wraps the same way.
REQ-018 SHALL apply per-edge priority: rst > redirect > flush > stall > normal advance.
REQ-019 SHALL, on redirect, load pc with redirect_pc and load IF/ID with a bubble; redirect overrides stall and flush.
REQ-020 SHALL, on flush without redirect, load IF/ID with a bubble and advance pc by 4 unless stall is also high, in which case pc holds.
REQ-021 SHALL, on stall alone, hold pc and every id_* output unchanged.
REQ-022 SHALL define a bubble as id_inst=0 (NOP), id_pc=0, id_pc4=0, id_valid=0.
REQ-023 SHALL not depend on the value of idata in cycles whose capture is a bubble.

Reset
REQ-024 SHALL, on rising clk with rst=1, set pc=RESET_PC, id_inst=0, id_pc=0, id_pc4=0, id_valid=0, misalign_err=0, overriding all other inputs.
REQ-025 SHALL capture the word at RESET_PC on the first edge after rst deasserts, producing id_valid=1 and id_pc=RESET_PC.
REQ-026 SHALL treat rst asserted mid-operation, including during a pending redirect or stall, identically to power-on reset.

Configuration
REQ-027 SHALL, with macro IF_ALIGN_CHECK_EN defined, treat a redirect with redirect_pc[1:0]!=0 as follows: set misalign_err=1 (sticky until rst), hold pc, force a bubble every cycle, and ignore all further redirects until rst.
REQ-028 SHALL, without IF_ALIGN_CHECK_EN, force redirect_pc[1:0] to 2'b00 on load and tie misalign_err to 0.

Verification
REQ-029 SHALL cover: imem word[0]=32'h20080005, word[1]=32'h20090003, rst held 2 cycles -> edge 1 gives id_inst=32'h20080005, id_pc=0, id_pc4=4, id_valid=1; edge 2 gives id_inst=32'h20090003, id_pc=4.
REQ-030 SHALL cover: stall=1 for 3 cycles with pc=32'h8 -> iaddr stays 32'h8 and id_* unchanged; after release the next capture has id_pc=32'h8.
REQ-031 SHALL cover: redirect=1, redirect_pc=32'h40 with pc=32'h10 -> next cycle iaddr=32'h40, id_valid=0, id_inst=0; the following cycle id_pc=32'h40, id_valid=1.
REQ-032 SHALL cover: redirect=1 and stall=1 together, redirect_pc=32'h80 -> iaddr=32'h80 next cycle and a bubble in IF/ID.
REQ-033 SHALL cover: flush=1 and stall=1 with pc=32'h20 -> iaddr stays 32'h20 and id_valid=0; with flush=1 alone -> iaddr=32'h24 and id_valid=0.
REQ-034 SHALL cover: pc forced to 32'hFFFFFFFC and redirect_pc=32'h42 -> wrap case gives iaddr=0 next cycle; misaligned redirect with IF_ALIGN_CHECK_EN gives misalign_err=1, pc held, id_valid=0; without the macro it gives iaddr=32'h40 and misalign_err=0.
